uart_line_echo: RTL and testbench

Line-oriented responder on the host side of the `uart` FIFO interface. It drains received bytes through `rd_uart`/`r_data`/`rx_empty` and assembles them into a line buffer until a carriage return arrives. It then writes the line back through `wr_uart`/`w_data`/`tx_full`, with lowercase letters folded to uppercase and CR LF appended. It sits directly beside `uart` in the top level and is the on-chip counterpart of the serial host that types lines into the link.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_line_buf.sv | 67 ++++++
 rtl/uart_line_echo.sv | 191 +++++++++++++++++++
 tb/tb_uart_line_echo.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the host-side line echo responder:
//   - echo_state_t      : FSM state encoding for uart_line_echo
//   - ASCII_* constants : control characters and the case-folding offset
//   - fold_upper()      : maps 'a'..'z' to 'A'..'Z', passes other bytes through
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_COLLECT   = 3'd0,
    ST_ECHO      = 3'd1,
    ST_SEND_BANG = 3'd2,
    ST_SEND_CR   = 3'd3,
    ST_SEND_LF   = 3'd4
  } echo_state_t;

  localparam logic [7:0] ASCII_CR          = 8'h0D;
  localparam logic [7:0] ASCII_LF          = 8'h0A;
  localparam logic [7:0] ASCII_BANG        = 8'h21;
  localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;
  localparam logic [7:0] ASCII_LOWER_A     = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z     = 8'h7A;

  function automatic logic [7:0] fold_upper(input logic [7:0] b);
    logic [7:0] r;
    if ((b >= ASCII_LOWER_A) && (b <= ASCII_LOWER_Z)) begin
      r = b - ASCII_CASE_OFFSET;
    end else begin
      r = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_line_buf.sv
// -----------------------------------------------------------------------------
// uart_line_buf
// LINE_MAX x 8 line storage with an append-only write port, a fill count and
// an indexed read mux.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   clr_i        : empty the buffer (count back to 0)
//   wr_en_i      : append wr_data_i at position count (ignored when full)
//   wr_data_i    : byte to append
//   rd_idx_i     : read index
//   count_o      : number of stored bytes
//   full_o       : count has reached LINE_MAX
//   rd_data_o    : stored byte at rd_idx_i (8'h00 beyond LINE_MAX)
// -----------------------------------------------------------------------------
module uart_line_buf #(
  parameter int LINE_MAX = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  input  logic [7:0] rd_idx_i,
  output logic [7:0] count_o,
  output logic       full_o,
  output logic [7:0] rd_data_o
);

  logic [7:0] mem_q [LINE_MAX];
  logic [7:0] count_q;
  logic       full_s;
  logic [7:0] rd_data_s;

  assign full_s = (count_q >= 8'(LINE_MAX));

  // Storage array and fill count; clear has priority over a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
      for (int i = 0; i < LINE_MAX; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (clr_i) begin
      count_q <= 8'd0;
    end else if (wr_en_i && !full_s) begin
      for (int i = 0; i < LINE_MAX; i++) begin
        if (count_q == 8'(i)) begin
          mem_q[i] <= wr_data_i;
        end
      end
      count_q <= count_q + 8'd1;
    end
  end

  // Read mux selecting the byte addressed by rd_idx_i.
  always_comb begin
    rd_data_s = 8'h00;
    for (int i = 0; i < LINE_MAX; i++) begin
      rd_data_s = (rd_idx_i == 8'(i)) ? mem_q[i] : rd_data_s;
    end
  end

  assign count_o   = count_q;
  assign full_o    = full_s;
  assign rd_data_o = rd_data_s;

endmodule

// File: rtl/uart_line_echo.sv
// -----------------------------------------------------------------------------
// uart_line_echo
// Host-side line responder beside the uart FIFOs. Collects received bytes
// into a line buffer until TERM, then echoes the line uppercased, followed by
// '!' if characters were dropped, then CR LF.
// Ports:
//   clk, reset  : 50 MHz clock, asynchronous active-high reset
//   rx_empty    : RX FIFO empty flag
//   r_data      : RX FIFO head byte
//   rd_uart     : one-cycle RX pop strobe (registered)
//   tx_full     : TX FIFO full flag
//   w_data      : byte pushed with wr_uart (registered)
//   wr_uart     : one-cycle TX push strobe (registered)
//   busy        : high whenever not collecting
//   line_count  : lines answered, wraps 255 -> 0
//   overflow    : a character of the current line was dropped
// -----------------------------------------------------------------------------
module uart_line_echo
  import uart_pkg::*;
#(
  parameter int         LINE_MAX = 32,
  parameter logic [7:0] TERM     = 8'h0D
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic [7:0] w_data,
  output logic       wr_uart,
  output logic       busy,
  output logic [7:0] line_count,
  output logic       overflow
);

  echo_state_t state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic        rd_uart_q, rd_uart_d;
  logic        wr_uart_q, wr_uart_d;
  logic [7:0]  w_data_q, w_data_d;
  logic        busy_q;
  logic [7:0]  line_count_q, line_count_d;
  logic        overflow_q, overflow_d;

  logic        buf_clr_s;
  logic        buf_wr_s;
  logic [7:0]  buf_count_s;
  logic        buf_full_s;
  logic [7:0]  buf_rd_s;
  logic        can_pop_s;
  logic        can_push_s;

  uart_line_buf #(
    .LINE_MAX (LINE_MAX)
  ) u_line_buf (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (buf_clr_s),
    .wr_en_i   (buf_wr_s),
    .wr_data_i (r_data),
    .rd_idx_i  (idx_q),
    .count_o   (buf_count_s),
    .full_o    (buf_full_s),
    .rd_data_o (buf_rd_s)
  );

  // A strobe issued last cycle blocks the next access so the FIFO flags
  // seen here are always up to date.
  assign can_pop_s  = !rx_empty && !rd_uart_q;
  assign can_push_s = !tx_full && !wr_uart_q;

  // Next-state logic for the collect/echo FSM and both FIFO strobes.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rd_uart_d    = 1'b0;
    wr_uart_d    = 1'b0;
    w_data_d     = w_data_q;
    line_count_d = line_count_q;
    overflow_d   = overflow_q;
    buf_clr_s    = 1'b0;
    buf_wr_s     = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        if (can_pop_s) begin
          rd_uart_d = 1'b1;
          // Terminator is checked first so it is never lost to a full buffer.
          if (r_data == TERM) begin
            state_d = ST_ECHO;
            idx_d   = 8'd0;
          end else if (r_data == ASCII_LF) begin
            state_d = ST_COLLECT;
          end else if (!buf_full_s) begin
            buf_wr_s = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end

      ST_ECHO: begin
        // The end check runs even while the previous push strobe is high,
        // so the trailer starts without an extra idle cycle.
        if (idx_q >= buf_count_s) begin
          state_d = overflow_q ? ST_SEND_BANG : ST_SEND_CR;
        end else if (can_push_s) begin
          wr_uart_d = 1'b1;
          w_data_d  = fold_upper(buf_rd_s);
          idx_d     = idx_q + 8'd1;
        end else begin
          state_d = ST_ECHO;
        end
      end

      ST_SEND_BANG: begin
        if (can_push_s) begin
          wr_uart_d = 1'b1;
          w_data_d  = ASCII_BANG;
          state_d   = ST_SEND_CR;
        end else begin
          state_d = ST_SEND_BANG;
        end
      end

      ST_SEND_CR: begin
        if (can_push_s) begin
          wr_uart_d = 1'b1;
          w_data_d  = ASCII_CR;
          state_d   = ST_SEND_LF;
        end else begin
          state_d = ST_SEND_CR;
        end
      end

      ST_SEND_LF: begin
        if (can_push_s) begin
          wr_uart_d    = 1'b1;
          w_data_d     = ASCII_LF;
          line_count_d = line_count_q + 8'd1;
          overflow_d   = 1'b0;
          buf_clr_s    = 1'b1;
          state_d      = ST_COLLECT;
        end else begin
          state_d = ST_SEND_LF;
        end
      end

      default: begin
        // Unreachable encoding: abandon the line and resume collecting.
        state_d    = ST_COLLECT;
        overflow_d = 1'b0;
        buf_clr_s  = 1'b1;
      end
    endcase
  end

  // State, strobe and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_COLLECT;
      idx_q        <= 8'd0;
      rd_uart_q    <= 1'b0;
      wr_uart_q    <= 1'b0;
      w_data_q     <= 8'h00;
      busy_q       <= 1'b0;
      line_count_q <= 8'd0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rd_uart_q    <= rd_uart_d;
      wr_uart_q    <= wr_uart_d;
      w_data_q     <= w_data_d;
      busy_q       <= (state_d != ST_COLLECT);
      line_count_q <= line_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign rd_uart    = rd_uart_q;
  assign wr_uart    = wr_uart_q;
  assign w_data     = w_data_q;
  assign busy       = busy_q;
  assign line_count = line_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_line_echo.sv
// -----------------------------------------------------------------------------
// tb_uart_line_echo
// Drives uart_line_echo (LINE_MAX=4) from an RX FIFO model. Expected TX bytes
// are hand-written strings pushed into a scoreboard queue; a monitor pops and
// compares on every wr_uart strobe.
// -----------------------------------------------------------------------------
module tb_uart_line_echo;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       tx_full;
  logic [7:0] w_data;
  logic       wr_uart;
  logic       busy;
  logic [7:0] line_count;
  logic       overflow;

  uart_line_echo #(
    .LINE_MAX (4),
    .TERM     (8'h0D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_empty   (rx_empty),
    .r_data     (r_data),
    .rd_uart    (rd_uart),
    .tx_full    (tx_full),
    .w_data     (w_data),
    .wr_uart    (wr_uart),
    .busy       (busy),
    .line_count (line_count),
    .overflow   (overflow)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       ovf;
    logic       last;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] rx_q  [$];

  int         vectors     = 0;
  int         miscompares = 0;
  int         rd_cnt      = 0;
  int         push_cnt    = 0;
  int         sent_cnt    = 0;
  logic [7:0] exp_lc      = 8'h00;
  logic       prev_rd     = 1'b0;
  logic       prev_wr     = 1'b0;
  logic       full_at_edge = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, expv);
    end
  endfunction

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      rx_q.push_back(s[i]);
      sent_cnt++;
    end
  endtask

  task automatic expect_str(input string s, input logic ovf);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.data = s[i];
      e.ovf  = ovf;
      e.last = (i == s.len() - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && rx_q.size() == 0 && !busy && !wr_uart) begin
        done = 1'b1;
      end
    end
    chk({name, "_timeout"}, 32'(done), 32'd1);
  endtask

  // tx_full as seen by the DUT at each active edge.
  initial begin
    forever begin
      @(posedge clk);
      full_at_edge = tx_full;
    end
  end

  // RX FIFO model: pop on each rd_uart pulse, present the new head.
  initial begin
    rx_empty = 1'b1;
    r_data   = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_uart && !reset && rx_q.size() > 0) begin
        void'(rx_q.pop_front());
      end
      rx_empty = (rx_q.size() == 0);
      r_data   = rx_empty ? 8'h00 : rx_q[0];
    end
  end

  // Monitor: strobe spacing, push gating and scoreboard comparison.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        exp_lc  = 8'h00;
        prev_rd = 1'b0;
        prev_wr = 1'b0;
      end else begin
        if (rd_uart) begin
          rd_cnt++;
          chk("rd_gap", 32'(prev_rd), 32'd0);
        end
        if (wr_uart) begin
          push_cnt++;
          chk("wr_gap", 32'(prev_wr), 32'd0);
          chk("push_while_full", 32'(full_at_edge), 32'd0);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_push: actual %0h required none", w_data);
          end else begin
            e = exp_q.pop_front();
            chk("w_data", 32'(w_data), 32'(e.data));
            chk("overflow", 32'(overflow), 32'(e.ovf && !e.last));
            chk("busy", 32'(busy), 32'(!e.last));
            if (e.last) begin
              exp_lc = exp_lc + 8'd1;
              chk("line_count", 32'(line_count), 32'(exp_lc));
            end
          end
        end
        prev_rd = rd_uart;
        prev_wr = wr_uart;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    logic found;
    reset   = 1'b1;
    tx_full = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd_uart", 32'(rd_uart), 32'd0);
    chk("rst_wr_uart", 32'(wr_uart), 32'd0);
    chk("rst_w_data", 32'(w_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_line_count", 32'(line_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;

    expect_str("HOLA\r\n", 1'b0);
    send_str("hola\r");
    wait_done("hola", 200);
    chk("hola_line_count", 32'(line_count), 32'd1);
    chk("hola_overflow", 32'(overflow), 32'd0);

    expect_str("\r\n", 1'b0);
    send_str("\r");
    wait_done("empty", 100);

    expect_str("A1B\r\n", 1'b0);
    send_str("a1B\n\r");
    wait_done("a1b", 200);

    expect_str("ABCD!\r\n", 1'b1);
    send_str("abcdef\r");
    wait_done("ovf", 200);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    expect_str("ABCD\r\n", 1'b0);
    send_str("abcd\r");
    wait_done("term_at_max", 200);

    expect_str("TEST\r\n", 1'b0);
    send_str("TEST\r");
    base  = push_cnt;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      #1;
      if (push_cnt >= base + 1) found = 1'b1;
    end
    chk("hold_first_push", 32'(found), 32'd1);
    tx_full = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    chk("hold_no_push", push_cnt, base + 1);
    tx_full = 1'b0;
    wait_done("hold", 200);
    chk("hold_line_count", 32'(line_count), 32'd6);

    expect_str("UART!\r\n", 1'b1);
    send_str("UART OK!\r");
    base  = push_cnt;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      #1;
      if (push_cnt >= base + 2) found = 1'b1;
    end
    chk("mid_echo_reached", 32'(found), 32'd1);
    chk("mid_echo_wr_high", 32'(wr_uart), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_wr_uart", 32'(wr_uart), 32'd0);
    chk("mid_rst_rd_uart", 32'(rd_uart), 32'd0);
    chk("mid_rst_line_count", 32'(line_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;

    expect_str("OK\r\n", 1'b0);
    send_str("ok\r");
    wait_done("after_rst", 200);
    chk("after_rst_line_count", 32'(line_count), 32'd1);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      expect_str("\r\n", 1'b0);
      send_str("\r");
    end
    wait_done("wrap", 6000);
    chk("wrap_line_count", 32'(line_count), 32'd0);

    repeat (4) @(negedge clk);
    #1;
    chk("rd_pulses", rd_cnt, sent_cnt);
    chk("exp_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
